// File: rtl/piso_serializer_pkg.sv
// rtl/piso_serializer_pkg.sv - shared state encoding and sizing helper for the PISO/SIPO stages
package piso_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Bit counter width for a WIDTH-bit word; never narrower than one bit.
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - load handshake, shift strobe and serial output bundle
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             bit_en;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    modport master (
        output din, load_valid, bit_en,
        input  load_ready, sout, sout_valid, busy, done
    );

    modport slave (
        input  din, load_valid, bit_en,
        output load_ready, sout, sout_valid, busy, done
    );
endinterface

// File: rtl/piso_serializer_mod_counter.sv
// rtl/piso_serializer_mod_counter.sv - bit counter that saturates at its terminal count
module piso_serializer_mod_counter #(
    parameter int MAX   = 3,
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [CNT_W-1:0] cnt;

    assign tc = (cnt == CNT_W'(MAX));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out stage with load handshake and shift strobe
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int   WIDTH      = 4,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input logic             clk,
    input logic             rst,
    piso_serializer_if.slave bus
);
    localparam int CNT_W = cnt_w(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             accept, step, last, tc;
    logic             sout_d;

    piso_serializer_mod_counter #(
        .MAX   (WIDTH - 1),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (step),
        .tc  (tc)
    );

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        accept  = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.load_valid) begin
                    accept  = 1'b1;
                    sr_d    = bus.din;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.bit_en) begin
                    if (tc) begin
                        last    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        step = 1'b1;
                        sr_d = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The send end of the register is always the bit on the wire next cycle.
    always_comb begin
        sout_d = IDLE_LEVEL;
        if (state_d == ST_SHIFT) begin
            sout_d = MSB_FIRST ? sr_d[WIDTH-1] : sr_d[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            sr_q           <= '0;
            bus.load_ready <= 1'b1;
            bus.sout       <= IDLE_LEVEL;
            bus.sout_valid <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            state_q        <= state_d;
            sr_q           <= sr_d;
            bus.load_ready <= (state_d == ST_IDLE);
            bus.sout       <= sout_d;
            bus.sout_valid <= (state_d == ST_SHIFT);
            bus.busy       <= (state_d == ST_SHIFT);
            bus.done       <= last;
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench driving MSB-first and LSB-first serializers in lockstep
module tb_piso_serializer;
    localparam int W = 4;

    typedef struct {
        int   cyc;
        logic b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    exp_t qb[2][$];
    int   dq[2][$];

    piso_serializer_if #(.WIDTH(W)) bus_m ();
    piso_serializer_if #(.WIDTH(W)) bus_l ();

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
        .clk (clk), .rst (rst), .bus (bus_m.slave)
    );
    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
        .clk (clk), .rst (rst), .bus (bus_l.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic [W-1:0] d, input logic lv, input logic be);
        bus_m.din = d;  bus_m.load_valid = lv;  bus_m.bit_en = be;
        bus_l.din = d;  bus_l.load_valid = lv;  bus_l.bit_en = be;
    endtask

    task automatic set_be(input logic be);
        bus_m.bit_en = be;
        bus_l.bit_en = be;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // pat[n-1] is the first bit on the wire, shown on cycle start
    task automatic push_bits(input int w, input int start, input logic [15:0] pat, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.cyc = start + i;
            e.b   = pat[n-1-i];
            qb[w].push_back(e);
        end
    endtask

    task automatic mon(input int w, input logic lr, input logic sv, input logic so,
                       input logic bz, input logic dn);
        exp_t e;
        while (qb[w].size() > 0 && qb[w][0].cyc < cyc) begin
            e = qb[w].pop_front();
            chk($sformatf("dut%0d missed bit due cyc %0d", w, e.cyc), 0, 1);
        end
        while (dq[w].size() > 0 && dq[w][0] < cyc) begin
            chk($sformatf("dut%0d missed done", w), 0, dq[w].pop_front());
        end
        if (sv) begin
            if (qb[w].size() == 0) begin
                chk($sformatf("dut%0d unexpected sout_valid", w), 1, 0);
            end else begin
                e = qb[w].pop_front();
                chk($sformatf("dut%0d bit cycle", w), cyc, e.cyc);
                chk($sformatf("dut%0d sout", w), int'(so), int'(e.b));
            end
        end else begin
            chk($sformatf("dut%0d sout idle level", w), int'(so), 0);
        end
        chk($sformatf("dut%0d busy vs sout_valid", w), int'(bz), int'(sv));
        chk($sformatf("dut%0d load_ready vs busy", w), int'(lr), int'(!bz));
        if (dn) begin
            if (dq[w].size() == 0) chk($sformatf("dut%0d unexpected done", w), 1, 0);
            else chk($sformatf("dut%0d done cycle", w), cyc, dq[w].pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, bus_m.load_ready, bus_m.sout_valid, bus_m.sout, bus_m.busy, bus_m.done);
            mon(1, bus_l.load_ready, bus_l.sout_valid, bus_l.sout, bus_l.busy, bus_l.done);
        end
    end

    int k;

    initial begin
        drive(4'b0000, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset load_ready", int'(bus_m.load_ready & bus_l.load_ready), 1);
        chk("reset sout_valid", int'(bus_m.sout_valid | bus_l.sout_valid), 0);
        chk("reset sout", int'(bus_m.sout | bus_l.sout), 0);
        chk("reset busy", int'(bus_m.busy | bus_l.busy), 0);
        chk("reset done", int'(bus_m.done | bus_l.done), 0);
        mon_en = 1'b1;

        // 1011 with bit_en held: MSB-first 1,0,1,1; LSB-first 1,1,0,1
        step(); k = cyc;
        drive(4'b1011, 1'b1, 1'b1);
        push_bits(0, k + 1, 16'b1011, 4);
        push_bits(1, k + 1, 16'b1101, 4);
        dq[0].push_back(k + 5); dq[1].push_back(k + 5);
        step();
        drive(4'b0000, 1'b0, 1'b1);
        @(negedge clk);
        chk("shift busy", int'(bus_m.busy & bus_l.busy), 1);
        chk("shift load_ready", int'(bus_m.load_ready | bus_l.load_ready), 0);
        repeat (6) step();

        // 1001 with bit_en 0,1,0,1...: every bit shown for two cycles
        k = cyc;
        drive(4'b1001, 1'b1, 1'b0);
        push_bits(0, k + 1, 16'b11000011, 8);
        push_bits(1, k + 1, 16'b11000011, 8);
        dq[0].push_back(k + 9); dq[1].push_back(k + 9);
        step();
        drive(4'b1001, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            set_be(i % 2 == 1);
            step();
        end
        set_be(1'b1);
        repeat (3) step();

        // 1011, then 0110 offered mid-word (ignored), then 0100 in the done cycle
        k = cyc;
        drive(4'b1011, 1'b1, 1'b1);
        push_bits(0, k + 1, 16'b1011, 4);
        push_bits(1, k + 1, 16'b1101, 4);
        push_bits(0, k + 6, 16'b0100, 4);
        push_bits(1, k + 6, 16'b0010, 4);
        dq[0].push_back(k + 5); dq[1].push_back(k + 5);
        dq[0].push_back(k + 10); dq[1].push_back(k + 10);
        step();
        drive(4'b0110, 1'b1, 1'b1);
        @(negedge clk);
        chk("busy load_ready while offered", int'(bus_m.load_ready | bus_l.load_ready), 0);
        repeat (4) step();
        drive(4'b0100, 1'b1, 1'b1);
        @(negedge clk);
        chk("done cycle load_ready", int'(bus_m.load_ready & bus_l.load_ready), 1);
        chk("done cycle done", int'(bus_m.done & bus_l.done), 1);
        step();
        drive(4'b0000, 1'b0, 1'b1);
        repeat (6) step();

        // reset after two bits of 1011, then 0011
        k = cyc;
        drive(4'b1011, 1'b1, 1'b1);
        push_bits(0, k + 1, 16'b10, 2);
        push_bits(1, k + 1, 16'b11, 2);
        step();
        drive(4'b1011, 1'b0, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("abort sout_valid", int'(bus_m.sout_valid | bus_l.sout_valid), 0);
        chk("abort load_ready", int'(bus_m.load_ready & bus_l.load_ready), 1);
        chk("abort done", int'(bus_m.done | bus_l.done), 0);
        step(); k = cyc;
        drive(4'b0011, 1'b1, 1'b1);
        push_bits(0, k + 1, 16'b0011, 4);
        push_bits(1, k + 1, 16'b1100, 4);
        dq[0].push_back(k + 5); dq[1].push_back(k + 5);
        step();
        drive(4'b0000, 1'b0, 1'b1);
        repeat (7) step();

        mon_en = 1'b0;
        for (int w = 0; w < 2; w++) begin
            chk($sformatf("dut%0d leftover bits", w), qb[w].size(), 0);
            chk($sformatf("dut%0d leftover dones", w), dq[w].size(), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
